// File: rtl/acc_reduce_pe.sv
// acc_reduce_pe: SIMD accumulate-and-reduce processing element.
// Accumulates L operand beats per lane (ADD or MAC, lane width 8/16/N_BITS),
// then reduces the lanes with a pairwise adder tree, one level per cycle,
// and presents the sign-extended sum on a valid/ready output.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   a_i, b_i             operand beat (N_BITS each)
//   valid_i / ready_o    operand handshake
//   op_i                 0 = lane a+b, 1 = lane a*b (low W bits)
//   vec_mode_i           00/11 = W=N_BITS, 01 = W=8, 10 = W=16
//   acc_len_i            beats per accumulation (0 behaves as 1)
//   clear_i              synchronous abort
//   res_o / valid_o      reduced result, held until ready_i

// One accumulator lane: computes f(a,b) and folds it into the running value.
module acc_reduce_pe_lane #(
    parameter int unsigned W        = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_acc,
    input  logic         i_op,
    input  logic         i_load,
    output logic [W-1:0] o_nxt_c
);
    localparam int unsigned W2 = 2 * W;
    localparam logic signed [W2-1:0] MAX_V = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [W2-1:0] MIN_V = {{(W + 1){1'b1}}, {(W - 1){1'b0}}};

    // Bring a double-width signed value back to W bits (clamp or wrap).
    function automatic logic [W-1:0] fit(input logic signed [W2-1:0] v);
        if (!SATURATE)      return v[W-1:0];
        else if (v > MAX_V) return MAX_V[W-1:0];
        else if (v < MIN_V) return MIN_V[W-1:0];
        else                return v[W-1:0];
    endfunction

    logic signed [W2-1:0] w_a_x;
    logic signed [W2-1:0] w_b_x;
    logic signed [W2-1:0] w_acc_x;
    logic signed [W2-1:0] w_op_x;
    logic signed [W2-1:0] w_f_x;
    logic signed [W2-1:0] w_sum_x;
    logic        [W-1:0]  w_f;

    // Double-width operands make both the sum and the product exact.
    assign w_a_x   = {{W{i_a[W-1]}}, i_a};
    assign w_b_x   = {{W{i_b[W-1]}}, i_b};
    assign w_acc_x = {{W{i_acc[W-1]}}, i_acc};
    assign w_op_x  = i_op ? (w_a_x * w_b_x) : (w_a_x + w_b_x);
    assign w_f     = fit(w_op_x);
    assign w_f_x   = {{W{w_f[W-1]}}, w_f};
    assign w_sum_x = w_acc_x + w_f_x;
    assign o_nxt_c = i_load ? w_f : fit(w_sum_x);
endmodule

module acc_reduce_pe #(
    parameter int unsigned N_BITS   = 32,
    parameter int unsigned CNT_BITS = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_BITS-1:0]   a_i,
    input  logic [N_BITS-1:0]   b_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                op_i,
    input  logic [1:0]          vec_mode_i,
    input  logic [CNT_BITS-1:0] acc_len_i,
    input  logic                clear_i,
    output logic [N_BITS-1:0]   res_o,
    output logic                valid_o,
    input  logic                ready_i
);
    localparam int unsigned NL8  = N_BITS / 8;
    localparam int unsigned NL16 = N_BITS / 16;
    localparam int unsigned LV8  = $clog2(NL8);
    localparam int unsigned LV16 = $clog2(NL16);
    localparam int unsigned LVW  = $clog2(LV8 + 1);

    localparam logic [1:0] MODE_FULL = 2'b00;
    localparam logic [1:0] MODE_8    = 2'b01;
    localparam logic [1:0] MODE_16   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC    = 2'd1,
        S_REDUCE = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t                r_state;
    logic [N_BITS-1:0]     r_acc;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  r_op;
    logic [1:0]            r_mode;
    logic [CNT_BITS-1:0]   r_len;
    logic [N_BITS-1:0]     r_red [NL8];
    logic [LVW-1:0]        r_lvl;
    logic [N_BITS-1:0]     r_res;
    logic                  r_valid;

    logic                  w_accept;
    logic                  w_first;
    logic                  w_op;
    logic [1:0]            w_mode_in;
    logic [1:0]            w_mode;
    logic [CNT_BITS-1:0]   w_len_in;
    logic [CNT_BITS-1:0]   w_len;
    logic [CNT_BITS-1:0]   w_cnt_nxt;
    logic                  w_last;
    logic [LVW-1:0]        w_levels;
    logic [N_BITS-1:0]     w_nxt8;
    logic [N_BITS-1:0]     w_nxt16;
    logic [N_BITS-1:0]     w_nxtn;
    logic [N_BITS-1:0]     w_acc_nxt;
    logic [N_BITS-1:0]     w_red_ld  [NL8];
    logic [N_BITS-1:0]     w_red_lvl [NL8];

    // Handshake: only IDLE/ACC take beats, and never while reset is held.
    assign ready_o  = ~rst_i & ((r_state == S_IDLE) | (r_state == S_ACC));
    assign w_accept = valid_i & ready_o;
    assign res_o    = r_res;
    assign valid_o  = r_valid;

    // The first beat uses live config; later beats use the sampled copy.
    assign w_first   = (r_state == S_IDLE);
    assign w_mode_in = (vec_mode_i == 2'b11) ? MODE_FULL : vec_mode_i;
    assign w_len_in  = (acc_len_i == '0) ? CNT_BITS'(1) : acc_len_i;
    assign w_op      = w_first ? op_i      : r_op;
    assign w_mode    = w_first ? w_mode_in : r_mode;
    assign w_len     = w_first ? w_len_in  : r_len;
    assign w_cnt_nxt = w_first ? CNT_BITS'(1) : (r_cnt + CNT_BITS'(1));
    assign w_last    = (w_cnt_nxt == w_len);

    // Number of tree levels needed for the active lane width.
    always_comb begin
        w_levels = '0;
        case (w_mode)
            MODE_8:  w_levels = LVW'(LV8);
            MODE_16: w_levels = LVW'(LV16);
            default: w_levels = '0;
        endcase
    end

    // Lane datapaths for every width; the active mode picks one set.
    for (genvar i = 0; i < NL8; i++) begin : g_l8
        acc_reduce_pe_lane #(.W(8), .SATURATE(SATURATE)) u_lane (
            .i_a     (a_i[i*8 +: 8]),
            .i_b     (b_i[i*8 +: 8]),
            .i_acc   (r_acc[i*8 +: 8]),
            .i_op    (w_op),
            .i_load  (w_first),
            .o_nxt_c (w_nxt8[i*8 +: 8])
        );
    end

    for (genvar i = 0; i < NL16; i++) begin : g_l16
        acc_reduce_pe_lane #(.W(16), .SATURATE(SATURATE)) u_lane (
            .i_a     (a_i[i*16 +: 16]),
            .i_b     (b_i[i*16 +: 16]),
            .i_acc   (r_acc[i*16 +: 16]),
            .i_op    (w_op),
            .i_load  (w_first),
            .o_nxt_c (w_nxt16[i*16 +: 16])
        );
    end

    acc_reduce_pe_lane #(.W(N_BITS), .SATURATE(SATURATE)) u_lane_full (
        .i_a     (a_i),
        .i_b     (b_i),
        .i_acc   (r_acc),
        .i_op    (w_op),
        .i_load  (w_first),
        .o_nxt_c (w_nxtn)
    );

    always_comb begin
        case (w_mode)
            MODE_8:  w_acc_nxt = w_nxt8;
            MODE_16: w_acc_nxt = w_nxt16;
            default: w_acc_nxt = w_nxtn;
        endcase
    end

    // Tree leaves: each lane sign-extended to full width so no level overflows.
    always_comb begin
        for (int i = 0; i < NL8; i++) begin
            w_red_ld[i] = '0;
        end
        for (int i = 0; i < NL8; i++) begin
            if (w_mode == MODE_8) begin
                w_red_ld[i] = {{(N_BITS - 8){w_acc_nxt[i*8 + 7]}}, w_acc_nxt[i*8 +: 8]};
            end else if ((w_mode == MODE_16) && (i < NL16)) begin
                w_red_ld[i] = {{(N_BITS - 16){w_acc_nxt[i*16 + 15]}}, w_acc_nxt[i*16 +: 16]};
            end
        end
    end

    // One tree level: entry i becomes the sum of entries 2i and 2i+1.
    always_comb begin
        for (int i = 0; i < NL8; i++) begin
            w_red_lvl[i] = '0;
        end
        for (int i = 0; i < NL8 / 2; i++) begin
            w_red_lvl[i] = r_red[2*i] + r_red[2*i + 1];
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_mode  <= MODE_FULL;
            r_len   <= '0;
            r_lvl   <= '0;
            r_res   <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < NL8; i++) begin
                r_red[i] <= '0;
            end
        end else if (clear_i) begin
            // Abort drops any partial or pending result; res_o keeps its value.
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_cnt_nxt;
                        if (w_first) begin
                            r_op   <= op_i;
                            r_mode <= w_mode_in;
                            r_len  <= w_len_in;
                        end
                        if (!w_last) begin
                            r_state <= S_ACC;
                        end else if (w_levels == '0) begin
                            // Single lane: nothing to reduce.
                            r_res   <= w_acc_nxt;
                            r_valid <= 1'b1;
                            r_state <= S_OUT;
                        end else begin
                            for (int i = 0; i < NL8; i++) begin
                                r_red[i] <= w_red_ld[i];
                            end
                            r_lvl   <= w_levels;
                            r_state <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE: begin
                    for (int i = 0; i < NL8; i++) begin
                        r_red[i] <= w_red_lvl[i];
                    end
                    r_lvl <= r_lvl - LVW'(1);
                    // Last level: its root is the final sum.
                    if (r_lvl == LVW'(1)) begin
                        r_res   <= w_red_lvl[0];
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_acc_reduce_pe.sv
// Bench for acc_reduce_pe: wrap and saturate instances share stimulus and are
// checked against a lane-level arithmetic reference model.
module tb_acc_reduce_pe;
    localparam int unsigned N  = 32;
    localparam int unsigned CB = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [N-1:0]  a_i;
    logic [N-1:0]  b_i;
    logic          valid_i;
    logic          op_i;
    logic [1:0]    vec_mode_i;
    logic [CB-1:0] acc_len_i;
    logic          clear_i;
    logic          ready_i;
    logic          ready0, ready1, valid0, valid1;
    logic [N-1:0]  res0, res1;

    int            n_vec = 0;
    int            n_err = 0;
    logic [N-1:0]  beat_a [64];
    logic [N-1:0]  beat_b [64];

    always #5 clk = ~clk;

    acc_reduce_pe #(.N_BITS(N), .CNT_BITS(CB), .SATURATE(1'b0)) u_dut_wrap (
        .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .valid_i(valid_i),
        .ready_o(ready0), .op_i(op_i), .vec_mode_i(vec_mode_i),
        .acc_len_i(acc_len_i), .clear_i(clear_i), .res_o(res0),
        .valid_o(valid0), .ready_i(ready_i)
    );

    acc_reduce_pe #(.N_BITS(N), .CNT_BITS(CB), .SATURATE(1'b1)) u_dut_sat (
        .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .valid_i(valid_i),
        .ready_o(ready1), .op_i(op_i), .vec_mode_i(vec_mode_i),
        .acc_len_i(acc_len_i), .clear_i(clear_i), .res_o(res1),
        .valid_o(valid1), .ready_i(ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic on plain signed integers.
    function automatic longint fit(input longint v, input int w, input bit sat);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        longint m  = longint'(1) <<< w;
        longint r;
        if (sat) begin
            r = (v > hi) ? hi : ((v < lo) ? lo : v);
        end else begin
            r = v % m;
            if (r > hi) r = r - m;
            if (r < lo) r = r + m;
        end
        return r;
    endfunction

    function automatic longint lane(input logic [31:0] x, input int w, input int i);
        logic [31:0] t;
        longint      v;
        t = x >> (i * w);
        v = longint'(t) & ((longint'(1) <<< w) - 1);
        if (v >= (longint'(1) <<< (w - 1))) v = v - (longint'(1) <<< w);
        return v;
    endfunction

    function automatic int lane_w(input logic [1:0] mode);
        return (mode == 2'b01) ? 8 : ((mode == 2'b10) ? 16 : 32);
    endfunction

    function automatic logic [31:0] model(input bit op, input logic [1:0] mode, input int nb, input bit sat);
        int     w = lane_w(mode);
        longint total = 0;
        for (int i = 0; i < 32 / w; i++) begin
            longint acc = 0;
            for (int j = 0; j < nb; j++) begin
                longint x = lane(beat_a[j], w, i);
                longint y = lane(beat_b[j], w, i);
                longint f = fit(op ? (x * y) : (x + y), w, sat);
                acc = (j == 0) ? f : fit(acc + f, w, sat);
            end
            total = total + acc;
        end
        return 32'(total);
    endfunction

    // Random traffic that the DUT must ignore (it is not ready).
    task automatic junk();
        valid_i    = 1'($urandom_range(0, 1));
        a_i        = $urandom;
        b_i        = $urandom;
        op_i       = 1'($urandom_range(0, 1));
        vec_mode_i = 2'($urandom_range(0, 3));
        acc_len_i  = 8'($urandom_range(0, 7));
    endtask

    task automatic drive_beat(input logic [31:0] a, input logic [31:0] b,
                              input bit op, input logic [1:0] mode, input logic [7:0] len);
        valid_i = 1'b1; a_i = a; b_i = b; op_i = op; vec_mode_i = mode; acc_len_i = len;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    // One full transaction: beats, reduce latency, output hold, handoff.
    task automatic run_txn(input bit op, input logic [1:0] mode, input logic [7:0] len,
                           input bit rnd, input int hold);
        int          nb = (len == 8'd0) ? 1 : int'(len);
        int          w  = lane_w(mode);
        int          lat = $clog2(32 / w);
        logic [31:0] e0, e1;
        if (rnd) begin
            for (int j = 0; j < nb; j++) begin
                beat_a[j] = $urandom;
                beat_b[j] = $urandom;
            end
        end
        e0 = model(op, mode, nb, 1'b0);
        e1 = model(op, mode, nb, 1'b1);
        for (int j = 0; j < nb; j++) begin
            while (rnd && $urandom_range(0, 3) == 0) begin
                valid_i = 1'b0; a_i = $urandom; b_i = $urandom;
                @(posedge clk); #1;
                chk("gap_ready", 32'(ready0), 32'd1);
                chk("gap_valid", 32'(valid0), 32'd0);
            end
            valid_i = 1'b1; a_i = beat_a[j]; b_i = beat_b[j];
            if (j == 0) begin
                op_i = op; vec_mode_i = mode; acc_len_i = len;
            end else begin
                op_i = 1'($urandom_range(0, 1));
                vec_mode_i = 2'($urandom_range(0, 3));
                acc_len_i = 8'($urandom_range(0, 7));
            end
            @(posedge clk); #1;
            if (j < nb - 1) chk("acc_valid", 32'(valid0), 32'd0);
        end
        ready_i = 1'b0;
        for (int k = 0; k < lat; k++) begin
            chk("red_valid", 32'(valid0), 32'd0);
            chk("red_ready", 32'(ready0), 32'd0);
            junk();
            @(posedge clk); #1;
        end
        chk("out_valid_wrap", 32'(valid0), 32'd1);
        chk("out_valid_sat", 32'(valid1), 32'd1);
        chk("res_wrap", res0, e0);
        chk("res_sat", res1, e1);
        chk("out_ready", 32'(ready0), 32'd0);
        for (int h = 0; h < hold; h++) begin
            junk();
            @(posedge clk); #1;
            chk("hold_res", res0, e0);
            chk("hold_valid", 32'(valid0), 32'd1);
            chk("hold_ready", 32'(ready0), 32'd0);
        end
        junk();
        ready_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; ready_i = 1'b0;
        chk("post_valid", 32'(valid0), 32'd0);
        chk("post_ready", 32'(ready0), 32'd1);
        chk("post_res", res0, e0);
    endtask

    initial begin
        logic [31:0] keep;
        rst_i = 1'b1; a_i = '0; b_i = '0; valid_i = 1'b0; op_i = 1'b0;
        vec_mode_i = 2'b00; acc_len_i = '0; clear_i = 1'b0; ready_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_res", res0, 32'd0);
        chk("rst_ready", 32'(ready0), 32'd0);
        rst_i = 1'b0; #1;
        chk("rel_ready", 32'(ready0), 32'd1);

        // Three-beat full-width add.
        beat_a[0] = 32'd1; beat_a[1] = 32'd2; beat_a[2] = 32'd3;
        beat_b[0] = 32'd0; beat_b[1] = 32'd0; beat_b[2] = 32'd0;
        run_txn(1'b0, 2'b00, 8'd3, 1'b0, 0);
        // Byte-lane MAC.
        beat_a[0] = 32'h02020202; beat_a[1] = 32'h02020202;
        beat_b[0] = 32'h03030303; beat_b[1] = 32'h03030303;
        run_txn(1'b1, 2'b01, 8'd2, 1'b0, 0);
        // Halfword overflow: wraps in one instance, clamps in the other.
        beat_a[0] = 32'h7FFF7FFF; beat_b[0] = 32'h00010001;
        run_txn(1'b0, 2'b10, 8'd1, 1'b0, 0);
        // Output held against back-pressure with beats pulsing.
        run_txn(1'b1, 2'b00, 8'd2, 1'b1, 4);

        // Abort after two of four beats.
        drive_beat($urandom, $urandom, 1'b0, 2'b00, 8'd4);
        drive_beat($urandom, $urandom, 1'b0, 2'b00, 8'd4);
        clear_i = 1'b1; valid_i = 1'b1; a_i = $urandom;
        @(posedge clk); #1;
        clear_i = 1'b0; valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("clr_valid", 32'(valid0), 32'd0);
            chk("clr_ready", 32'(ready0), 32'd1);
            @(posedge clk); #1;
        end
        beat_a[0] = 32'd9; beat_b[0] = 32'd0;
        run_txn(1'b0, 2'b00, 8'd1, 1'b0, 0);

        // Abort with a result pending in OUT: dropped, res_o keeps its value.
        beat_a[0] = $urandom; beat_b[0] = $urandom;
        keep = model(1'b0, 2'b00, 1, 1'b0);
        drive_beat(beat_a[0], beat_b[0], 1'b0, 2'b00, 8'd1);
        chk("pend_valid", 32'(valid0), 32'd1);
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        chk("drop_valid", 32'(valid0), 32'd0);
        chk("drop_ready", 32'(ready0), 32'd1);
        chk("drop_res", res0, keep);

        // Reset while reducing.
        drive_beat($urandom, $urandom, 1'b1, 2'b01, 8'd1);
        chk("rr_ready", 32'(ready0), 32'd0);
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("rr_valid", 32'(valid0), 32'd0);
        chk("rr_res", res0, 32'd0);
        chk("rr_ready_in", 32'(ready0), 32'd0);
        rst_i = 1'b0; #1;
        chk("rr_ready_rel", 32'(ready0), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rr_valid_after", 32'(valid0), 32'd0);
        end

        // Randomised transactions over all modes and lengths.
        for (int t = 0; t < 60; t++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 5)), 1'b1, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/acc_reduce_pe.md
ACC_REDUCE_PE -- requirements
Module: acc_reduce_pe

Interface
REQ-001 SHALL have parameter N_BITS, default 32, datapath width; a power of two and at least 32.
REQ-002 SHALL have parameter CNT_BITS, default 8, width of the accumulation-length counter.
REQ-003 SHALL have parameter SATURATE, default 0; 1 selects per-lane signed saturation, 0 selects two's-complement wrap.
REQ-004 SHALL have port clk_i, input, 1 bit, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, reset; synchronous, active-high.
REQ-006 SHALL have ports a_i and b_i, inputs, N_BITS each, operands.
REQ-007 SHALL have port valid_i, input, 1 bit, operand beat valid.
REQ-008 SHALL have port ready_o, output, 1 bit; a beat is accepted when valid_i and ready_o are both 1.
REQ-009 SHALL have port op_i, input, 1 bit: 0 = ADD (lane a+b), 1 = MAC (lane a*b, low W bits).
REQ-010 SHALL have port vec_mode_i, input, 2 bits: 00 = lane width W=N_BITS, 01 = W=8, 10 = W=16, 11 treated as 00.
REQ-011 SHALL have port acc_len_i, input, CNT_BITS, beats per accumulation L; 0 treated as 1.
REQ-012 SHALL have port clear_i, input, 1 bit, synchronous abort.
REQ-013 SHALL have port res_o, output, N_BITS, reduced result.
REQ-014 SHALL have port valid_o, output, 1 bit, result valid.
REQ-015 SHALL have port ready_i, input, 1 bit, consumer ready; result taken when valid_o and ready_i are both 1.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, REDUCE and OUT.
REQ-017 SHALL sample op_i, vec_mode_i and acc_len_i on the first accepted beat and hold them until return to IDLE.
REQ-018 IDLE and ACC SHALL drive ready_o=1; REDUCE and OUT SHALL drive ready_o=0.
REQ-019 IDLE, on an accepted beat, SHALL load each lane accumulator with f(a,b) and set count=1; it SHALL go to REDUCE if L=1, else to ACC.
REQ-020 ACC, on an accepted beat, SHALL add f(a,b) into each lane accumulator and increment count; on count==L it SHALL go to REDUCE.
REQ-021 With no accepted beat, ACC SHALL hold state, accumulators and count unchanged; there is no timeout.
REQ-022 Lane arithmetic SHALL be signed W-bit: wrap when SATURATE=0; when SATURATE=1, clamp products and sums to [-2^(W-1), 2^(W-1)-1] at each step.
REQ-023 REDUCE SHALL pairwise-sum lanes, one tree level per cycle, for log2(N_BITS/W) cycles; each level widens the sum by 1 bit, so the reduction never overflows.
REQ-024 When log2(N_BITS/W)=0, REDUCE SHALL take zero cycles and ACC/IDLE SHALL go directly to OUT.
REQ-025 The final sum SHALL be sign-extended to N_BITS.
REQ-026 Latency: last beat accepted at edge t SHALL give valid_o=1 from edge t+1+log2(N_BITS/W).
REQ-027 OUT SHALL drive valid_o=1 with res_o stable until ready_i=1, then return to IDLE on the next edge; valid_o SHALL be 0 in all other states.
REQ-028 Beats presented while ready_o=0 SHALL be ignored and leave no side effect.
REQ-029 clear_i=1 SHALL, on the next edge, force IDLE and zero the accumulators, count and valid_o.
REQ-030 clear_i SHALL have priority over every event except rst_i; a beat presented with clear_i=1 SHALL be discarded.
REQ-031 A result pending in OUT when clear_i=1 SHALL be dropped.
REQ-032 res_o SHALL hold its last value outside OUT; it is not cleared except by rst_i.

Reset
REQ-033 rst_i=1 at an edge SHALL set state IDLE and zero the accumulators, count, sampled config, res_o and valid_o.
REQ-034 ready_o SHALL be 0 while rst_i=1 and 1 in the first cycle after release.
REQ-035 Reset asserted mid-accumulation or in OUT SHALL discard all partial and pending results.

Verification
REQ-036 Scenario (N_BITS=32 here and below): vec 00, ADD, L=3, a=1,2,3 and b=0 on consecutive cycles -> res_o=6, valid_o high 1 cycle after the third beat.
REQ-037 Scenario: vec 01, MAC, L=2, a=0x02020202 and b=0x03030303 twice -> each lane 12, res_o=0x00000030, valid_o 3 cycles after the last beat.
REQ-038 Scenario: vec 10, ADD, L=1, SATURATE=0, a=0x7FFF7FFF, b=0x00010001 -> res_o=0xFFFF0000; with SATURATE=1 -> res_o=0x0000FFFE; valid_o 2 cycles after the beat.
REQ-039 Scenario: result in OUT with ready_i held 0 for 4 cycles while valid_i pulses -> res_o stable, ready_o=0, beats ignored; ready_i=1 -> IDLE next cycle.
REQ-040 Scenario: clear_i pulsed after 2 of L=4 beats -> no valid_o; then vec 00, L=1, a=9, b=0 -> res_o=9.
REQ-041 Scenario: rst_i asserted in REDUCE -> valid_o stays 0, res_o=0, ready_o=1 in the first cycle after release.
